// File: rtl/instr_encoder_pkg.sv
// Shared encodings, opcodes and immediate limits for the RV32I instruction encoder.
package instr_encoder_pkg;

  localparam int XLEN = 32;

  // Format codes mirror the decoder's imm_src encoding.
  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_U   = 3'b011,
    FMT_J   = 3'b100,
    FMT_SH  = 3'b101,
    FMT_ILL = 3'b110,
    FMT_R   = 3'b111
  } fmt_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STYPE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM13_MIN = -4096;
  localparam int signed IMM13_MAX = 4094;
  localparam int signed IMM21_MIN = -1048576;
  localparam int signed IMM21_MAX = 1048574;
  localparam int signed SHAMT_MAX = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } bundle_t;

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational packer: format + fields + signed immediate -> RV32I word and a
// flag telling whether the decoder would reproduce the immediate exactly.
module instr_encoder_imm_packer
  import instr_encoder_pkg::*;
(
  input  logic [2:0]             fmt_i,
  input  logic [6:0]             opcode_i,
  input  logic [4:0]             rd_i,
  input  logic [4:0]             rs1_i,
  input  logic [4:0]             rs2_i,
  input  logic [2:0]             funct3_i,
  input  logic [6:0]             funct7_i,
  input  logic signed [XLEN-1:0] imm_i,
  output logic [XLEN-1:0]        instr_o,
  output logic                   legal_o
);

  function automatic logic in_range(input logic signed [XLEN-1:0] v,
                                    input int signed lo, input int signed hi);
    return (v >= lo) && (v <= hi);
  endfunction

  always_comb begin
    instr_o = '0;
    legal_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_SH: begin
        instr_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = in_range(imm_i, 0, SHAMT_MAX);
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      // Branch and jump offsets drop bit 0, so it must already be clear.
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        legal_o = in_range(imm_i, IMM13_MIN, IMM13_MAX) && !imm_i[0];
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        legal_o = (imm_i[11:0] == 12'd0);
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal_o = in_range(imm_i, IMM21_MIN, IMM21_MAX) && !imm_i[0];
      end
      default: begin
        instr_o = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Loader-side instruction encoder: accepts field bundles, packs them into RV32I
// words and writes them to program memory at an auto-incrementing address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            fmt_i,
  input  logic [6:0]            opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic                  mem_ack_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  err_o,
  output logic [2:0]            err_code_o
);

  state_e                state_q;
  logic                  ready_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  err_q;
  logic [2:0]            code_q;
  bundle_t               req_q;

  logic [XLEN-1:0]       packed_instr;
  logic                  packed_legal;
  logic                  accept;

  assign accept  = (state_q == ST_IDLE) && ready_q && req_valid_i && !load_i;
  assign count_d = (count_q == {CNT_WIDTH{1'b1}}) ? count_q : count_q + CNT_WIDTH'(1);

  // Captured fields are pure data; they are only consumed in CHECK after a capture.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_q <= '{fmt: fmt_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                 funct3: funct3_i, funct7: funct7_i, imm: imm_i};
    end
  end

  instr_encoder_imm_packer u_packer (
    .fmt_i    (req_q.fmt),
    .opcode_i (req_q.opcode),
    .rd_i     (req_q.rd),
    .rs1_i    (req_q.rs1),
    .rs2_i    (req_q.rs2),
    .funct3_i (req_q.funct3),
    .funct7_i (req_q.funct7),
    .imm_i    (req_q.imm),
    .instr_o  (packed_instr),
    .legal_o  (packed_legal)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else if (load_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= base_addr_i & ~ADDR_WIDTH'(3);
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_CHECK;
            ready_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (packed_legal) begin
            data_q  <= packed_instr;
            wr_q    <= 1'b1;
            state_q <= ST_WRITE;
          end else begin
            err_q   <= 1'b1;
            if (!err_q) code_q <= req_q.fmt;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (mem_ack_i) begin
            wr_q    <= 1'b0;
            addr_q  <= addr_q + ADDR_WIDTH'(4);
            count_q <= count_d;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign mem_wr_o    = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign count_o     = count_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder; written words are decoded
// back with a reference immediate decoder and compared with the requested fields.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        load_i;
  logic [31:0] base_addr_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;
  logic [15:0] count_o;
  logic        err_o;
  logic [2:0]  err_code_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural expectations
  logic [31:0] exp_addr;
  int          exp_count;
  logic        exp_err;
  logic [2:0]  exp_code;

  instr_encoder dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .load_i      (load_i),
    .base_addr_i (base_addr_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .fmt_i       (fmt_i),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .imm_i       (imm_i),
    .mem_wr_o    (mem_wr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_ack_i   (mem_ack_i),
    .count_o     (count_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Legality from the immediate ranges the decoder can reproduce.
  function automatic bit legal_m(input logic [2:0] f, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (f)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      3'd3:       return (imm % 4096) == 0;
      3'd4:       return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      3'd5:       return (v >= 0) && (v <= 31);
      3'd7:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference immediate decoder of the core.
  function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'b0};
      3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'd5:    return {27'b0, w[24:20]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] want_imm(input logic [2:0] f, input logic [31:0] imm);
    case (f)
      3'd3:    return imm & 32'hFFFF_F000;
      3'd5:    return {27'b0, imm[4:0]};
      3'd7:    return 32'd0;
      default: return imm;
    endcase
  endfunction

  function automatic bit fields_ok(input logic [31:0] w, input bundle_t b);
    bit ok;
    ok = (w[6:0] == b.opcode);
    if (b.fmt inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd7}) ok = ok && (w[11:7] == b.rd);
    if (b.fmt inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd7})
      ok = ok && (w[19:15] == b.rs1) && (w[14:12] == b.funct3);
    if (b.fmt inside {3'd1, 3'd2, 3'd7}) ok = ok && (w[24:20] == b.rs2);
    if (b.fmt inside {3'd5, 3'd7}) ok = ok && (w[31:25] == b.funct7);
    return ok;
  endfunction

  task automatic present(input bundle_t b);
    fmt_i = b.fmt; opcode_i = b.opcode; rd_i = b.rd; rs1_i = b.rs1; rs2_i = b.rs2;
    funct3_i = b.funct3; funct7_i = b.funct7; imm_i = b.imm;
    req_valid_i = 1'b1;
  endtask

  // Present, wait (bounded) for ready, take the accept edge and the CHECK edge.
  task automatic start(input bundle_t b);
    int w;
    present(b);
    w = 0;
    while (!req_ready_o && w < 10) begin
      tick();
      w++;
    end
    chk("ready_before_accept", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    chk("ready_in_check", 32'(req_ready_o), 32'd0);
    tick();
  endtask

  task automatic do_load(input logic [31:0] base);
    load_i = 1'b1;
    base_addr_i = base;
    tick();
    load_i = 1'b0;
    exp_addr = base & 32'hFFFF_FFFC;
    exp_count = 0;
    exp_err = 1'b0;
    exp_code = 3'd0;
    chk("load_addr", mem_addr_o, exp_addr);
    chk("load_count", 32'(count_o), 32'd0);
    chk("load_err", 32'(err_o), 32'd0);
  endtask

  task automatic finish_bundle(input bundle_t b, input int ack_delay, output logic [31:0] word);
    word = 32'd0;
    if (legal_m(b.fmt, b.imm)) begin
      chk("strobe", 32'(mem_wr_o), 32'd1);
      chk("wr_addr", mem_addr_o, exp_addr);
      word = mem_data_o;
      chk("roundtrip_imm", dec_imm(b.fmt, word), want_imm(b.fmt, b.imm));
      chk("roundtrip_fields", 32'(fields_ok(word, b)), 32'd1);
      for (int i = 0; i < ack_delay; i++) begin
        tick();
        chk("hold_wr", 32'(mem_wr_o), 32'd1);
        chk("hold_addr", mem_addr_o, exp_addr);
        chk("hold_data", mem_data_o, word);
        chk("hold_ready", 32'(req_ready_o), 32'd0);
      end
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      exp_addr = exp_addr + 32'd4;
      if (exp_count < 65535) exp_count++;
      chk("wr_dropped", 32'(mem_wr_o), 32'd0);
      chk("next_addr", mem_addr_o, exp_addr);
      chk("count", 32'(count_o), 32'(exp_count));
    end else begin
      if (!exp_err) exp_code = b.fmt;
      exp_err = 1'b1;
      chk("rej_no_wr", 32'(mem_wr_o), 32'd0);
      chk("rej_err", 32'(err_o), 32'(exp_err));
      chk("rej_code", 32'(err_code_o), 32'(exp_code));
      chk("rej_count", 32'(count_o), 32'(exp_count));
      chk("rej_ready", 32'(req_ready_o), 32'd1);
    end
  endtask

  task automatic run_bundle(input bundle_t b, input int ack_delay, output logic [31:0] word);
    start(b);
    finish_bundle(b, ack_delay, word);
  endtask

  function automatic bundle_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [31:0] imm);
    bundle_t b;
    b = '{fmt: f, opcode: op, rd: rd, rs1: rs1, rs2: rs2, funct3: f3, funct7: 7'd0, imm: imm};
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int signed lo, hi;
    int r;
    logic [2:0] fsel [8];
    fsel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6};
    r = $urandom_range(0, 15);
    b.fmt = (r < 14) ? fsel[r % 7] : 3'd6;
    b.opcode = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom); b.funct3 = 3'($urandom); b.funct7 = 7'($urandom);
    case (b.fmt)
      3'd0, 3'd1: begin lo = -2048;    hi = 2047;    end
      3'd2:       begin lo = -4096;    hi = 4094;    end
      3'd4:       begin lo = -1048576; hi = 1048574; end
      3'd5:       begin lo = 0;        hi = 31;      end
      default:    begin lo = 0;        hi = 0;       end
    endcase
    r = $urandom_range(0, 9);
    if (b.fmt == 3'd3) b.imm = (r == 2) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_F000);
    else if (b.fmt inside {3'd6, 3'd7} || r == 2) b.imm = 32'($urandom);
    else if (r == 0) b.imm = 32'(lo);
    else if (r == 1) b.imm = 32'(hi);
    else if (r == 3) b.imm = 32'(hi + 1);
    else begin
      b.imm = 32'(lo + int'($urandom_range(0, 32'(hi - lo))));
      if (b.fmt inside {3'd2, 3'd4}) b.imm[0] = 1'b0;
    end
    return b;
  endfunction

  initial begin
    logic [31:0] word;
    bundle_t b;
    reset_ni = 1'b0; load_i = 1'b0; base_addr_i = 32'd0; req_valid_i = 1'b0;
    fmt_i = 3'd0; opcode_i = 7'd0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    funct3_i = 3'd0; funct7_i = 7'd0; imm_i = 32'd0; mem_ack_i = 1'b0;
    exp_addr = 32'd0; exp_count = 0; exp_err = 1'b0; exp_code = 3'd0;
    tick(); tick();
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_wr", 32'(mem_wr_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_data", mem_data_o, 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();

    // addi x1, x0, -1 at 0x100, ack in the first WRITE cycle
    do_load(32'h100);
    run_bundle(mk(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF), 0, word);
    chk("addi_word", word, 32'hFFF0_0093);

    // beq x1, x2, +8 then an odd branch offset
    run_bundle(mk(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8), 0, word);
    chk("beq_word", word, 32'h0020_8463);
    run_bundle(mk(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd7), 0, word);
    chk("beq_odd_code", 32'(err_code_o), 32'd2);

    // Ack withheld for 5 cycles
    run_bundle(mk(3'd1, 7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFF_F800), 5, word);

    // mem_ack_i while idle must not count or move the address
    mem_ack_i = 1'b1;
    tick(); tick();
    mem_ack_i = 1'b0;
    chk("idle_ack_count", 32'(count_o), 32'(exp_count));
    chk("idle_ack_addr", mem_addr_o, exp_addr);

    // load with a bundle in the same cycle: bundle not accepted
    present(mk(3'd0, 7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 32'd5));
    load_i = 1'b1; base_addr_i = 32'h0000_0403;
    tick();
    load_i = 1'b0; req_valid_i = 1'b0;
    exp_addr = 32'h400; exp_count = 0; exp_err = 1'b0; exp_code = 3'd0;
    chk("load_vs_valid_ready", 32'(req_ready_o), 32'd1);
    chk("load_vs_valid_addr", mem_addr_o, 32'h400);
    tick();
    chk("load_vs_valid_no_wr", 32'(mem_wr_o), 32'd0);

    // Randomized round trip across all formats
    for (int n = 0; n < 80; n++) begin
      b = rand_bundle();
      run_bundle(b, int'($urandom_range(0, 3)), word);
    end

    // load in the middle of a WRITE aborts it
    start(mk(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000));
    chk("pre_abort_wr", 32'(mem_wr_o), 32'd1);
    do_load(32'h200);
    chk("abort_wr", 32'(mem_wr_o), 32'd0);
    chk("abort_ready", 32'(req_ready_o), 32'd1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("abort_no_count", 32'(count_o), 32'd0);

    // Address wrap at the top of memory
    do_load(32'hFFFF_FFFE);
    chk("wrap_base", mem_addr_o, 32'hFFFF_FFFC);
    run_bundle(mk(3'd7, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0), 1, word);
    chk("wrap_addr", mem_addr_o, 32'd0);

    // Asynchronous reset between edges in WRITE
    start(mk(3'd3, 7'b0010111, 5'd7, 5'd0, 5'd0, 3'd0, 32'hABCD_E000));
    chk("pre_reset_wr", 32'(mem_wr_o), 32'd1);
    #3 reset_ni = 1'b0;
    #1;
    chk("areset_wr", 32'(mem_wr_o), 32'd0);
    chk("areset_addr", mem_addr_o, 32'd0);
    chk("areset_data", mem_data_o, 32'd0);
    chk("areset_count", 32'(count_o), 32'd0);
    chk("areset_ready", 32'(req_ready_o), 32'd1);
    chk("areset_err", 32'(err_o), 32'd0);
    #2 reset_ni = 1'b1;
    tick();
    exp_addr = 32'd0; exp_count = 0; exp_err = 1'b0; exp_code = 3'd0;
    run_bundle(mk(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000), 0, word);
    chk("lui_word", word, 32'h1234_52B7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
